// File: rtl/pi_request_arbiter.sv
// ---------------------------------------------------------------------------
// pi_request_arbiter
//
// Request stage of the priority-interrupt (PI) system. It sits directly
// upstream of the 8-input priority encoder. Channel 0 has the highest
// priority and channel 7 the lowest, which matches the encoder's bit order.
//
// The block does four things:
//   - merges hardware request levels and software request bits into a
//     pending vector;
//   - masks that vector with the channel enables and with the in-progress
//     (hold) levels, and drives the result to the encoder;
//   - registers the encoder's answer as an interrupt request to the CPU;
//   - tracks nested in-progress levels through the ack/dismiss handshake.
//
// Optional feature macro: PI_REQ_SYNC_EN
//   Defined     : each req_in bit passes through a 2-flop synchronizer.
//   Not defined : req_in is used directly and no synchronizer flops exist.
//
// Ports:
//   clk        in   clock
//   reset      in   asynchronous, active-high reset
//   pi_on      in   PI system enable; when low, no channel is eligible
//   req_in     in   [0:7] hardware request levels
//   sw_set     in   [0:7] one-cycle pulses that set software request bits
//   sw_clr     in   [0:7] one-cycle pulses that clear software request bits
//   chan_en    in   [0:7] channel enable mask
//   enc_q      in   [0:2] encoded level returned by the encoder
//   enc_any    in   encoder "some input set" flag
//   ack        in   CPU grant of the level currently on irq_level
//   dismiss    in   ends service of the highest-priority held level
//   enc_d      out  [0:7] eligible request vector, fed to the encoder
//   irq        out  registered interrupt request to the CPU
//   irq_level  out  [0:2] registered level offered to the CPU
//   sw_req     out  [0:7] software request register
//   hold       out  [0:7] in-progress levels
// ---------------------------------------------------------------------------
module pi_request_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       pi_on,
    input  logic [0:7] req_in,
    input  logic [0:7] sw_set,
    input  logic [0:7] sw_clr,
    input  logic [0:7] chan_en,
    input  logic [0:2] enc_q,
    input  logic       enc_any,
    input  logic       ack,
    input  logic       dismiss,
    output logic [0:7] enc_d,
    output logic       irq,
    output logic [0:2] irq_level,
    output logic [0:7] sw_req,
    output logic [0:7] hold
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic       irq_q, irq_d;
    logic [0:2] irq_level_q, irq_level_d;
    logic [0:7] sw_req_q, sw_req_d;
    logic [0:7] hold_q, hold_d;

    logic [0:7] req_s;
    logic [0:7] pend_s;
    logic [0:7] blocked_s;
    logic       blk_run_s;
    logic [0:7] low_hold_s;
    logic       low_found_s;
    logic       grant_s;
    logic [0:7] grant_vec_s;
    logic [0:7] enc_d_s;

`ifdef PI_REQ_SYNC_EN
    logic [0:7] sync1_q, sync2_q;

    // Two-flop synchronizer for requests arriving from asynchronous devices.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 8'h00;
            sync2_q <= 8'h00;
        end else begin
            sync1_q <= req_in;
            sync2_q <= sync1_q;
        end
    end

    assign req_s = sync2_q;
`else
    assign req_s = req_in;
`endif

    // A held level blocks itself and every lower-priority (higher-index) channel.
    always_comb begin
        blocked_s = 8'h00;
        blk_run_s = 1'b0;
        for (int n = 0; n < 8; n++) begin
            blk_run_s    = blk_run_s | hold_q[n];
            blocked_s[n] = blk_run_s;
        end
    end

    // Lowest-index set bit of hold: the level that a dismiss releases.
    always_comb begin
        low_hold_s  = 8'h00;
        low_found_s = 1'b0;
        for (int n = 0; n < 8; n++) begin
            low_hold_s[n] = hold_q[n] & ~low_found_s;
            low_found_s   = low_found_s | hold_q[n];
        end
    end

    // Pending and eligible request vectors presented to the encoder.
    always_comb begin
        pend_s = req_s | sw_req_q;
        if (pi_on) begin
            enc_d_s = pend_s & chan_en & ~blocked_s;
        end else begin
            enc_d_s = 8'h00;
        end
    end

    // Handshake FSM: next state, offered level and grant decision.
    always_comb begin
        state_d     = state_q;
        irq_level_d = irq_level_q;
        grant_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // ack in IDLE has no effect.
                if (enc_any && pi_on) begin
                    state_d     = ST_PEND;
                    irq_level_d = enc_q;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (ack) begin
                    state_d = ST_IDLE;
                    grant_s = 1'b1;
                end else if (enc_any && pi_on) begin
                    // Track the encoder so a higher request can pre-empt.
                    state_d     = ST_PEND;
                    irq_level_d = enc_q;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        irq_d = (state_d == ST_PEND);
    end

    // Grant, dismiss and software-request register updates.
    always_comb begin
        grant_vec_s = 8'h00;
        if (grant_s) begin
            grant_vec_s[irq_level_q] = 1'b1;
        end else begin
            grant_vec_s = 8'h00;
        end
        // Dismiss acts on the old hold; the new grant bit is ORed in afterwards.
        if (dismiss) begin
            hold_d = (hold_q & ~low_hold_s) | grant_vec_s;
        end else begin
            hold_d = hold_q | grant_vec_s;
        end
        // Set wins over both sw_clr and a grant-induced clear.
        sw_req_d = (sw_req_q & ~(sw_clr | grant_vec_s)) | sw_set;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            irq_q       <= 1'b0;
            irq_level_q <= 3'd0;
            sw_req_q    <= 8'h00;
            hold_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            irq_q       <= irq_d;
            irq_level_q <= irq_level_d;
            sw_req_q    <= sw_req_d;
            hold_q      <= hold_d;
        end
    end

    assign enc_d     = enc_d_s;
    assign irq       = irq_q;
    assign irq_level = irq_level_q;
    assign sw_req    = sw_req_q;
    assign hold      = hold_q;

endmodule
